// File: rtl/sha3_pkg.sv
// Constants and FSM encoding shared by the SHA3 rate-block padder and the SHA3 core top.
package sha3_pkg;

  localparam int RATE_BYTES = 136;
  localparam int RATE_BITS  = RATE_BYTES * 8;

  localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
  localparam logic [7:0] SHA3_PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    PADX = 2'd2
  } pad_state_e;

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational masking/padding of one input word destined for rate-block slot `slot`.
module sha3_pad_word
  import sha3_pkg::*;
#(
  parameter int RATE_BYTES = sha3_pkg::RATE_BYTES,
  parameter int DATA_BYTES = 8,
  parameter int SLOT_W     = $clog2(RATE_BYTES / DATA_BYTES)
) (
  input  logic [DATA_BYTES*8-1:0] word,
  input  logic [3:0]              n_bytes,
  input  logic [SLOT_W-1:0]       slot,
  input  logic                    last,
  output logic [DATA_BYTES*8-1:0] slot_val,
  output logic                    pad_next,
  output logic [7:0]              last_or
);

  localparam int DW = DATA_BYTES * 8;
  localparam int PW = $clog2(RATE_BYTES + DATA_BYTES + 1);

  logic [PW-1:0] pad_pos;

  always_comb begin
    slot_val = word;
    pad_next = 1'b0;
    last_or  = 8'h00;
    pad_pos  = PW'(slot) * PW'(DATA_BYTES) + PW'(n_bytes);
    if (last) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (b >= int'(n_bytes)) slot_val[DW-1-8*b -: 8] = 8'h00;
        if (b == int'(n_bytes)) slot_val[DW-1-8*b -: 8] = SHA3_PAD_FIRST;
      end
      // A full last word below the final slot pushes 0x06 into the next slot.
      if (pad_pos <= PW'(RATE_BYTES - 1)) begin
        last_or  = SHA3_PAD_LAST;
        pad_next = (int'(n_bytes) == DATA_BYTES);
      end
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// Gathers 64-bit message words into SHA3 rate blocks with 0x06..0x80 padding.
// Optional byte-length output enabled by defining SHA3_PAD_MSGLEN_EN.
//
// state | meaning
// FILL  | accepting words into slot wcnt
// SEND  | block held on blk until blk_ready
// PADX  | build the padding-only block after a rate-aligned message
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int RATE_BYTES = sha3_pkg::RATE_BYTES,
  parameter int DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_BYTES*8-1:0] din,
  input  logic [3:0]              din_bytes,
  input  logic                    din_last,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [RATE_BYTES*8-1:0] blk,
  output logic                    blk_more,
  output logic                    blk_valid,
`ifdef SHA3_PAD_MSGLEN_EN
  output logic [63:0]             msg_len,
`endif
  input  logic                    blk_ready
);

  localparam int DW        = DATA_BYTES * 8;
  localparam int NUM_SLOTS = RATE_BYTES / DATA_BYTES;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  pad_state_e state_q, state_d;
  // Element NUM_SLOTS-1 holds message slot 0 so the packed array maps straight onto blk.
  logic [NUM_SLOTS-1:0][DW-1:0] buf_q, buf_d;
  logic [SLOT_W-1:0] wcnt_q, wcnt_d;
  logic              more_q, more_d;
  logic              pend_q, pend_d;

  logic [SLOT_W-1:0] slot_idx;
  logic [3:0]        n_eff;
  logic [DW-1:0]     slot_val;
  logic              pad_next;
  logic [7:0]        last_or;
  logic              accept;

  assign n_eff    = !din_last ? 4'(DATA_BYTES) :
                    (din_bytes > 4'(DATA_BYTES)) ? 4'(DATA_BYTES) : din_bytes;
  assign slot_idx = LAST_SLOT - wcnt_q;
  assign accept   = (state_q == FILL) && din_valid;

  sha3_pad_word #(
    .RATE_BYTES(RATE_BYTES),
    .DATA_BYTES(DATA_BYTES),
    .SLOT_W    (SLOT_W)
  ) u_pad_word (
    .word    (din),
    .n_bytes (n_eff),
    .slot    (wcnt_q),
    .last    (din_last),
    .slot_val(slot_val),
    .pad_next(pad_next),
    .last_or (last_or)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    wcnt_d    = wcnt_q;
    more_d    = more_q;
    pend_d    = pend_q;
    din_ready = 1'b0;
    blk_valid = 1'b0;
    case (state_q)
      FILL: begin
        din_ready = 1'b1;
        if (din_valid) begin
          buf_d[slot_idx] = slot_val;
          if (din_last) begin
            buf_d[0][7:0] = buf_d[0][7:0] | last_or;
            if (pad_next) buf_d[slot_idx - 1'b1][DW-1 -: 8] = SHA3_PAD_FIRST;
            // No 0x80 term means the message filled the block exactly.
            more_d  = (last_or == 8'h00);
            pend_d  = (last_or == 8'h00);
            state_d = SEND;
          end else if (wcnt_q == LAST_SLOT) begin
            more_d  = 1'b1;
            state_d = SEND;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          buf_d   = '0;
          wcnt_d  = '0;
          state_d = pend_q ? PADX : FILL;
        end
      end
      PADX: begin
        buf_d                       = '0;
        buf_d[NUM_SLOTS-1][DW-1 -: 8] = SHA3_PAD_FIRST;
        buf_d[0][7:0]               = SHA3_PAD_LAST;
        more_d                      = 1'b0;
        pend_d                      = 1'b0;
        state_d                     = SEND;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      buf_q   <= '0;
      wcnt_q  <= '0;
      more_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      wcnt_q  <= wcnt_d;
      more_q  <= more_d;
      pend_q  <= pend_d;
    end
  end

  assign blk      = buf_q;
  assign blk_more = more_q;

`ifdef SHA3_PAD_MSGLEN_EN
  logic [63:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if ((state_q == SEND) && blk_ready && !more_q) len_d = '0;
    else if (accept) len_d = len_q + 64'(n_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) len_q <= '0;
    else        len_q <= len_d;
  end

  assign msg_len = len_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_sha3_padder.sv
// Randomized self-checking bench for sha3_padder against a byte-queue padding model.
module tb_sha3_padder;

  localparam int RB = 136;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   din = '0;
  logic [3:0]    din_bytes = '0;
  logic          din_last = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [1087:0] blk;
  logic          blk_more;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
`ifdef SHA3_PAD_MSGLEN_EN
  logic [63:0]   msg_len;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sha3_padder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_bytes(din_bytes),
    .din_last (din_last),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .blk      (blk),
    .blk_more (blk_more),
    .blk_valid(blk_valid),
`ifdef SHA3_PAD_MSGLEN_EN
    .msg_len  (msg_len),
`endif
    .blk_ready(blk_ready)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_msg(input bq_t msg, input bit empty_tail, input bit oversize);
    int len;
    int nw;
    int n;
    int t;
    logic [63:0] d;
    len = msg.size();
    nw  = (len + 7) / 8;
    if (len == 0 || (empty_tail && (len % 8) == 0)) nw++;
    for (int w = 0; w < nw; w++) begin
      n = len - 8 * w;
      if (n > 8) n = 8;
      if (n < 0) n = 0;
      d = {$urandom, $urandom};
      for (int b = 0; b < n; b++) d[63-8*b -: 8] = msg[8*w+b];
      din       = d;
      din_last  = (w == nw - 1);
      din_bytes = (w == nw - 1) ? 4'(n) : 4'($urandom_range(0, 15));
      if ((w == nw - 1) && n == 8 && oversize) din_bytes = 4'($urandom_range(9, 15));
      din_valid = 1'b1;
      t = 0;
      while (!din_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!din_ready) begin
        failures++;
        $display("FAIL din_wait: din_ready=%0b after %0d cycles, required 1", din_ready, t);
        din_valid = 1'b0;
        return;
      end
      @(negedge clk);
      din_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic collect_msg(input bq_t msg, input bit empty_tail, input int stall_first);
    bq_t pad;
    int nblk;
    int t;
    int dly;
    logic [1087:0] exp;
    logic exp_more;
    logic exp_rdy;
    pad = msg;
    pad.push_back(8'h06);
    while ((pad.size() % RB) != 0) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
    nblk = pad.size() / RB;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < RB; k++) exp[1087-8*k -: 8] = pad[b*RB+k];
      exp_more = (b < nblk - 1);
      t = 0;
      while (!blk_valid && t < 3000) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!blk_valid) begin
        failures++;
        $display("FAIL blk_wait: blk_valid=0 after %0d cycles (len=%0d blk=%0d), required 1", t, msg.size(), b);
        return;
      end
      checks++;
      if (blk !== exp || blk_more !== exp_more) begin
        failures++;
        $display("FAIL block len=%0d idx=%0d: more=%0b first16=%h last16=%h, required more=%0b first16=%h last16=%h",
                 msg.size(), b, blk_more, blk[1087 -: 128], blk[127:0], exp_more, exp[1087 -: 128], exp[127:0]);
      end
`ifdef SHA3_PAD_MSGLEN_EN
      if (!exp_more) begin
        checks++;
        if (msg_len !== 64'(msg.size())) begin
          failures++;
          $display("FAIL msg_len: got %0d, required %0d", msg_len, msg.size());
        end
      end
`endif
      dly = (b == 0) ? stall_first : $urandom_range(0, 3);
      blk_ready = 1'b0;
      for (int s = 0; s < dly; s++) begin
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b1 || blk !== exp || blk_more !== exp_more || din_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall cycle %0d: valid=%0b more=%0b din_ready=%0b blk_eq=%0b, required valid=1 more=%0b din_ready=0 blk_eq=1",
                   s, blk_valid, blk_more, din_ready, (blk === exp), exp_more);
        end
      end
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      // Only a rate-aligned message ending in a full word needs the extra padding cycle.
      exp_rdy = !((b == nblk - 2) && (msg.size() % RB) == 0 && msg.size() > 0 && !empty_tail);
      checks++;
      if (din_ready !== exp_rdy) begin
        failures++;
        $display("FAIL post_handshake din_ready: got %0b, required %0b (len=%0d blk=%0d)",
                 din_ready, exp_rdy, msg.size(), b);
      end
    end
  endtask

  task automatic run_msg(input bq_t msg, input bit empty_tail, input bit oversize, input int stall_first);
    fork
      drive_msg(msg, empty_tail, oversize);
      collect_msg(msg, empty_tail, stall_first);
    join
  endtask

  function automatic bq_t rand_msg(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0 || din_ready !== 1'b1 || blk_more !== 1'b0 || blk !== '0) begin
      failures++;
      $display("FAIL reset: valid=%0b din_ready=%0b more=%0b blk_zero=%0b, required 0 1 0 1",
               blk_valid, din_ready, blk_more, (blk === '0));
    end
`ifdef SHA3_PAD_MSGLEN_EN
    checks++;
    if (msg_len !== 64'd0) begin
      failures++;
      $display("FAIL reset msg_len: got %0d, required 0", msg_len);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    bq_t q;
    run_msg(q, 1'b0, 1'b0, 0);
  endtask

  task automatic test_abc();
    bq_t q;
    q = '{8'h61, 8'h62, 8'h63};
    run_msg(q, 1'b0, 1'b0, 1);
  endtask

  task automatic test_boundaries();
    run_msg(rand_msg(135), 1'b0, 1'b0, 0);
    run_msg(rand_msg(136), 1'b0, 1'b0, 2);
    run_msg(rand_msg(136), 1'b0, 1'b1, 0);
    run_msg(rand_msg(136), 1'b1, 1'b0, 0);
    run_msg(rand_msg(128), 1'b0, 1'b0, 0);
    run_msg(rand_msg(134), 1'b0, 1'b0, 0);
    run_msg(rand_msg(272), 1'b0, 1'b0, 0);
  endtask

  task automatic test_clamp_and_tail();
    run_msg(rand_msg(16), 1'b0, 1'b1, 0);
    run_msg(rand_msg(24), 1'b1, 1'b0, 0);
    run_msg(rand_msg(8), 1'b0, 1'b1, 0);
  endtask

  task automatic test_stall();
    run_msg(rand_msg(150), 1'b0, 1'b0, 10);
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 25; m++) begin
      run_msg(rand_msg($urandom_range(0, 300)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 5; w++) begin
      din       = {$urandom, $urandom};
      din_bytes = 4'd8;
      din_last  = 1'b0;
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0 || din_ready !== 1'b1 || blk !== '0) begin
      failures++;
      $display("FAIL reset_mid: valid=%0b din_ready=%0b blk_zero=%0b, required 0 1 1",
               blk_valid, din_ready, (blk === '0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_msg(rand_msg(20), 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_boundaries();
    test_clamp_and_tail();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
